// File: rtl/csa_mac_accumulator.sv
// Carry-save multiply-accumulate front end: compresses each 8x8 product into
// redundant sum/carry rows and presents the closed group on a valid/ready port.
module csa_mac_accumulator #(
  parameter int MAX_TERMS = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_w,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [19:0] out_sum,
  output logic [19:0] out_carry,
  output logic [4:0]  out_count
);

  typedef enum logic {ACC, HOLD} state_t;

  localparam logic [4:0] MAX_N = 5'(MAX_TERMS);

  state_t      state_q, state_d;
  logic [19:0] s_q, s_d, c_q, c_d;
  logic [4:0]  n_q, n_d;
  logic [19:0] out_sum_q, out_sum_d, out_carry_q, out_carry_d;
  logic [4:0]  out_count_q, out_count_d;

  logic [15:0] prod;
  logic [19:0] p, s_new, c_new, maj;
  logic [4:0]  n_new;
  logic        term_hs, out_hs, close;

  // Rows are cleared whenever a group closes, so a term taken while in HOLD
  // naturally starts a fresh group from zero without a separate path.
  always_comb begin
    prod  = in_a * in_w;
    p     = {4'b0, prod};
    s_new = s_q ^ c_q ^ p;
    maj   = (s_q & c_q) | (s_q & p) | (c_q & p);
    c_new = {maj[18:0], 1'b0};
    n_new = n_q + 5'd1;
  end

  always_comb begin
    in_ready = reset_n & ((state_q == ACC) | out_ready);
    term_hs  = in_valid & in_ready;
    out_hs   = (state_q == HOLD) & out_ready;
    close    = term_hs & (in_last | (n_new == MAX_N));
  end

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    c_d         = c_q;
    n_d         = n_q;
    out_sum_d   = out_sum_q;
    out_carry_d = out_carry_q;
    out_count_d = out_count_q;
    if (close) begin
      s_d         = '0;
      c_d         = '0;
      n_d         = '0;
      out_sum_d   = s_new;
      out_carry_d = c_new;
      out_count_d = n_new;
      state_d     = HOLD;
    end else if (term_hs) begin
      s_d     = s_new;
      c_d     = c_new;
      n_d     = n_new;
      state_d = ACC;
    end else if (out_hs) begin
      state_d = ACC;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ACC;
      s_q         <= '0;
      c_q         <= '0;
      n_q         <= '0;
      out_sum_q   <= '0;
      out_carry_q <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      c_q         <= c_d;
      n_q         <= n_d;
      out_sum_q   <= out_sum_d;
      out_carry_q <= out_carry_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign out_sum   = out_sum_q;
  assign out_carry = out_carry_q;
  assign out_count = out_count_q;

endmodule
